// File: rtl/bus_fifo_pkg.sv
// Shared definitions for the per-device bus FIFO, the arbiter and the agent.
package bus_fifo_pkg;

  localparam int ID_W      = 8;
  localparam int PAYLOAD_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'd145;

  // Packet layout for the default 16-bit packet: destination ID in the top byte.
  typedef struct packed {
    logic [ID_W-1:0]      dest_id;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/bus_dev_fifo_if.sv
// Device/arbiter-facing signal bundle of one bus_dev_fifo instance.
interface bus_dev_fifo_if #(
  parameter int PCKG_SZ = 16,
  parameter int DEPTH   = 8,
  parameter int DRP_W   = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Handshake: a push is taken on a rising edge when push=1 and (full=0 or a
  // legal pop happens on the same edge); a pop is taken when pop=1 and pndng=1.
  // D_pop is show-ahead: it is the packet consumed by the next legal pop.
  logic               push;
  logic [PCKG_SZ-1:0] D_push;
  logic               full;
  logic               pop;
  logic [PCKG_SZ-1:0] D_pop;
  logic               pndng;
  logic [CNT_W-1:0]   count;
  logic [DRP_W-1:0]   drop_cnt;
  logic               undrflw;

  modport master (
    output push, D_push, pop,
    input  full, D_pop, pndng, count, drop_cnt, undrflw
  );

  modport slave (
    input  push, D_push, pop,
    output full, D_pop, pndng, count, drop_cnt, undrflw
  );

endinterface

// File: rtl/bus_fifo_mem.sv
// Packet storage: register array with synchronous write and asynchronous read.
module bus_fifo_mem #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8,
  parameter int ptr_w   = 3
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [ptr_w-1:0]   waddr_i,
  input  logic [pckg_sz-1:0] wdata_i,
  input  logic [ptr_w-1:0]   raddr_i,
  output logic [pckg_sz-1:0] rdata_o
);

  logic [pckg_sz-1:0] mem_q [depth];

  // Contents are intentionally not reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_dev_fifo.sv
// Per-device transmit FIFO feeding the bus arbiter, with show-ahead head data,
// occupancy, saturating drop counter and sticky underflow flag.
module bus_dev_fifo
  import bus_fifo_pkg::*;
#(
  parameter int pckg_sz = 16,
  parameter int depth   = 8,
  parameter int drp_w   = 8
) (
  input  logic         clk,
  input  logic         reset,
  bus_dev_fifo_if.slave bus
);

  localparam int PTR_W = ptr_w(depth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(depth);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pndng_q, pndng_d;
  logic             full_q, full_d;
  logic [drp_w-1:0] drop_q, drop_d;
  logic             undrflw_q, undrflw_d;

  logic               empty;
  logic               do_pop;
  logic               do_push;
  logic               drop_req;
  logic [pckg_sz-1:0] rd_data;

  assign empty    = (count_q == '0);
  assign do_pop   = bus.pop && !empty;
  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_push  = bus.push && ((count_q != DEPTH_C) || do_pop);
  assign drop_req = bus.push && !do_push;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    drop_d    = drop_q;
    undrflw_d = undrflw_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
    if (drop_req && (drop_q != '1)) drop_d = drop_q + 1'b1;
    if (bus.pop && empty) undrflw_d = 1'b1;
    pndng_d = (count_d != '0);
    full_d  = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pndng_q   <= 1'b0;
      full_q    <= 1'b0;
      drop_q    <= '0;
      undrflw_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pndng_q   <= pndng_d;
      full_q    <= full_d;
      drop_q    <= drop_d;
      undrflw_q <= undrflw_d;
    end
  end

  bus_fifo_mem #(
    .pckg_sz (pckg_sz),
    .depth   (depth),
    .ptr_w   (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.D_push),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign bus.D_pop    = pndng_q ? rd_data : '0;
  assign bus.pndng    = pndng_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;
  assign bus.drop_cnt = drop_q;
  assign bus.undrflw  = undrflw_q;

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Directed bench for bus_dev_fifo: expected packets go into a queue when pushed
// and a negedge monitor checks D_pop against it whenever a legal pop is presented.
module tb_bus_dev_fifo;
  import bus_fifo_pkg::*;

  logic clk;
  logic reset;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] exp_q[$];

  bus_dev_fifo_if #(.PCKG_SZ(16), .DEPTH(8), .DRP_W(8)) bus_a ();
  bus_dev_fifo_if #(.PCKG_SZ(16), .DEPTH(8), .DRP_W(2)) bus_b ();

  bus_dev_fifo #(.pckg_sz(16), .depth(8), .drp_w(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  bus_dev_fifo #(.pckg_sz(16), .depth(8), .drp_w(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, need finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: apply one cycle of stimulus to dut_a; acc says whether the push
  // is expected to be accepted, in which case its data joins the scoreboard.
  task automatic drive_a(input logic p, input logic [15:0] d, input logic q, input bit acc);
    bus_a.push   = p;
    bus_a.D_push = d;
    bus_a.pop    = q;
    if (p && acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    bus_a.push   = 1'b0;
    bus_a.D_push = '0;
    bus_a.pop    = 1'b0;
  endtask

  task automatic drive_b(input logic p, input logic [15:0] d);
    bus_b.push   = p;
    bus_b.D_push = d;
    @(posedge clk);
    #1;
    bus_b.push   = 1'b0;
    bus_b.D_push = '0;
  endtask

  // Monitor: a legal pop consumes the presented head packet.
  always @(negedge clk) begin
    if (!reset && bus_a.pop && bus_a.pndng) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(bus_a.D_pop), 32'hDEAD_BEEF);
      end else begin
        check("pop_data", 32'(bus_a.D_pop), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    pkt_t pk;
    reset = 1'b1;
    bus_a.push = 1'b0; bus_a.D_push = '0; bus_a.pop = 1'b0;
    bus_b.push = 1'b0; bus_b.D_push = '0; bus_b.pop = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset then idle
    check("rst_pndng",   32'(bus_a.pndng),    32'd0);
    check("rst_full",    32'(bus_a.full),     32'd0);
    check("rst_count",   32'(bus_a.count),    32'd0);
    check("rst_drop",    32'(bus_a.drop_cnt), 32'd0);
    check("rst_dpop",    32'(bus_a.D_pop),    32'd0);
    check("rst_undrflw", 32'(bus_a.undrflw),  32'd0);

    // Fill 0x0101..0x0808
    for (int i = 1; i <= 8; i++) begin
      drive_a(1'b1, {i[7:0], i[7:0]}, 1'b0, 1'b1);
      if (i == 1) begin
        check("showahead_dpop",  32'(bus_a.D_pop), 32'h0101);
        check("showahead_pndng", 32'(bus_a.pndng), 32'd1);
      end
    end
    check("fill_full",  32'(bus_a.full),  32'd1);
    check("fill_count", 32'(bus_a.count), 32'd8);

    // Overflow: three rejected pushes
    for (int i = 0; i < 3; i++) drive_a(1'b1, 16'hAAAA, 1'b0, 1'b0);
    check("ovf_drop",  32'(bus_a.drop_cnt), 32'd3);
    check("ovf_count", 32'(bus_a.count),    32'd8);
    check("ovf_head",  32'(bus_a.D_pop),    32'h0101);

    // Drain
    for (int i = 0; i < 8; i++) drive_a(1'b0, '0, 1'b1, 1'b0);
    check("drain_pndng", 32'(bus_a.pndng), 32'd0);
    check("drain_count", 32'(bus_a.count), 32'd0);
    check("drain_dpop",  32'(bus_a.D_pop), 32'd0);
    check("drain_sb",    32'(exp_q.size()), 32'd0);

    // Saturating drop counter on the 2-bit instance
    for (int i = 1; i <= 8; i++) drive_b(1'b1, 16'h4000 + 16'(i));
    for (int i = 0; i < 6; i++) drive_b(1'b1, 16'hBBBB);
    check("sat_drop",  32'(bus_b.drop_cnt), 32'd3);
    check("sat_count", 32'(bus_b.count),    32'd8);
    check("sat_head",  32'(bus_b.D_pop),    32'h4001);

    // Wrap: push 5, pop 5, push 6
    for (int i = 1; i <= 5; i++) drive_a(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive_a(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) drive_a(1'b1, 16'h1100 + 16'(i), 1'b0, 1'b1);
    check("wrap_count", 32'(bus_a.count), 32'd6);
    check("wrap_head",  32'(bus_a.D_pop), 32'h1101);

    // Simultaneous push/pop at count 6
    for (int i = 1; i <= 4; i++) begin
      drive_a(1'b1, 16'h2000 + 16'(i), 1'b1, 1'b1);
      check("sim_count", 32'(bus_a.count), 32'd6);
    end
    check("sim_head", 32'(bus_a.D_pop), 32'h1105);

    // Top up to full, then push+pop while full
    drive_a(1'b1, 16'h3001, 1'b0, 1'b1);
    drive_a(1'b1, 16'h3002, 1'b0, 1'b1);
    check("full2_full", 32'(bus_a.full), 32'd1);
    drive_a(1'b1, 16'hBEEF, 1'b1, 1'b1);
    check("fullpp_count", 32'(bus_a.count),    32'd8);
    check("fullpp_drop",  32'(bus_a.drop_cnt), 32'd3);
    check("fullpp_full",  32'(bus_a.full),     32'd1);
    for (int i = 0; i < 8; i++) drive_a(1'b0, '0, 1'b1, 1'b0);
    check("drain2_count", 32'(bus_a.count),  32'd0);
    check("drain2_sb",    32'(exp_q.size()), 32'd0);

    // Underflow
    drive_a(1'b0, '0, 1'b1, 1'b0);
    check("udf_flag",  32'(bus_a.undrflw), 32'd1);
    check("udf_count", 32'(bus_a.count),   32'd0);
    drive_a(1'b1, 16'h1234, 1'b1, 1'b1);
    check("udfpp_count", 32'(bus_a.count),   32'd1);
    check("udfpp_dpop",  32'(bus_a.D_pop),   32'h1234);
    check("udfpp_flag",  32'(bus_a.undrflw), 32'd1);

    // Async reset mid-stream at count 5
    for (int i = 1; i <= 4; i++) drive_a(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b1);
    check("pre_rst_count", 32'(bus_a.count), 32'd5);
    #2 reset = 1'b1;
    #1;
    check("arst_count",   32'(bus_a.count),    32'd0);
    check("arst_pndng",   32'(bus_a.pndng),    32'd0);
    check("arst_full",    32'(bus_a.full),     32'd0);
    check("arst_dpop",    32'(bus_a.D_pop),    32'd0);
    check("arst_undrflw", 32'(bus_a.undrflw),  32'd0);
    check("arst_drop",    32'(bus_b.drop_cnt), 32'd0);
    exp_q.delete();
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    pk.dest_id = BROADCAST_ID;
    pk.payload = 8'hFF;
    drive_a(1'b1, pk, 1'b0, 1'b1);
    check("post_rst_dpop",  32'(bus_a.D_pop), 32'h91FF);
    check("post_rst_pndng", 32'(bus_a.pndng), 32'd1);
    check("post_rst_count", 32'(bus_a.count), 32'd1);
    drive_a(1'b0, '0, 1'b1, 1'b0);
    check("final_sb", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_dev_fifo.md
Name: bus_dev_fifo

Overview:
- Per-device transmit FIFO sitting directly upstream of the bus generator/arbiter (bs_gnrtr_n_rbtr); one instance per device port.
- The device side (agent/driver) pushes packets into it.
- It presents show-ahead head data on D_pop with a pending flag to the arbiter, which pops on grant.
- Also tracks occupancy, dropped pushes and illegal pops for the checker/scoreboard.

Parameters:
- pckg_sz, 16, packet width in bits; upper 8 bits [pckg_sz-1 -: 8] are the destination ID.
- depth, 8, FIFO depth in packets; power of two, >= 2.
- drp_w, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  device writes D_push this cycle.
- D_push  in  pckg_sz  packet from device.
- full  out  1  FIFO holds depth entries.
- pop  in  1  arbiter consumes head this cycle.
- D_pop  out  pckg_sz  head packet, show-ahead.
- pndng  out  1  FIFO non-empty.
- count  out  $clog2(depth)+1  current occupancy, 0..depth.
- drop_cnt  out  drp_w  pushes rejected while full; saturates at all-ones.
- undrflw  out  1  sticky: pop seen while empty.

Behaviour:
- Reset (async assert, released on clk edge):
  - rd_ptr = wr_ptr = 0, count = 0, pndng = 0, full = 0, drop_cnt = 0, undrflw = 0.
  - D_pop = 0 while empty.
  - Memory contents are not cleared.
- Storage: circular buffer of depth entries; pointers are $clog2(depth) bits and wrap depth-1 -> 0 with no special case.
- Status outputs are registered (derived from registered count):
  - pndng = (count != 0); full = (count == depth).
  - D_pop = mem[rd_ptr] when pndng, else 0.
  - Zero-latency show-ahead: a packet pushed at edge N is visible on D_pop, with pndng = 1, after edge N when the FIFO was empty.
- Push only, not full: mem[wr_ptr] <= D_push, wr_ptr++, count++.
- Push only, full: write ignored; contents, pointers and count unchanged; drop_cnt++ unless already all-ones.
- Pop only, non-empty: rd_ptr++, count--. D_pop shows the next entry after the edge, or 0 if the FIFO is now empty.
- Pop only, empty: no state change; undrflw <= 1. It stays 1 until reset.
- Push and pop, 0 < count < depth: write and read both happen, count unchanged, both pointers advance.
- Push and pop, full: legal. The pop frees a slot, so the write is accepted, no drop, count stays depth.
- Push and pop, empty: the pop is illegal and ignored, undrflw <= 1. The push is accepted, count becomes 1.
- No state machine beyond pointer/count; count is the single source of truth for empty/full.
- Reset mid-operation: immediate flush to the reset state. In-flight packets are lost; the testbench must account for them.
- The destination ID field is not interpreted here. Broadcast handling belongs to the arbiter.

Decomposition:
- Shared package bus_fifo_pkg:
  - ID_W = 8.
  - BROADCAST_ID = 8'd145.
  - Function ptr_w(depth) returning $clog2(depth).
  - Typedef for the packet struct: {dest_id, payload}, reused by the arbiter and the agent.
- One natural sub-module, bus_fifo_mem:
  - depth x pckg_sz register array, synchronous write, asynchronous read.
  - Keeps the control logic in bus_dev_fifo free of storage.

Test Plan:
- Reset then idle: after reset deasserts, pndng = 0, full = 0, count = 0, drop_cnt = 0, D_pop = 0, undrflw = 0.
- Fill/drain (depth = 8): push 0x0101..0x0808 on 8 consecutive edges.
  - full = 1 and count = 8 after the 8th edge.
  - pop 8 times: D_pop returns 0x0101..0x0808 in order, pndng = 0 after the last pop.
- Overflow: fill to 8, push 0xAAAA three more times.
  - drop_cnt = 3, count = 8, and 0xAAAA never appears on D_pop.
  - With drp_w = 2, six overflow pushes leave drop_cnt = 3 (saturated).
- Wrap and simultaneous: push 5, pop 5, then push 6 to wrap the pointers.
  - Assert push and pop together for 4 cycles while count = 6: count stays 6, data order preserved.
  - Full plus push and pop: no drop, count = 8.
- Underflow: pop while empty gives undrflw = 1 and count = 0. Push and pop together on empty gives count = 1, D_pop = pushed value, undrflw = 1.
- Async reset mid-stream: with count = 5, pulse reset between clock edges.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - A subsequent push of 0x91FF shows D_pop = 0x91FF with pndng = 1.
